// File: rtl/bitrev_pkg.sv
// Shared defaults and state encoding for the bitrev core and its front-end arbiter.
package bitrev_pkg;

    localparam int K_DEF  = 10;
    localparam int DW_DEF = 32;
    localparam int N_DEF  = 1 << K_DEF;

    typedef enum logic {
        IDLE,
        LOAD
    } bra_state_e;

endpackage

// File: rtl/bitrev_tag_fifo.sv
// In-order queue of frame owners; a full queue still accepts a push when a pop happens in the same cycle.
module bitrev_tag_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Tag storage only matters while occupied, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bitrev_arbiter.sv
// Frame-granular round-robin sharing of one bitrev core between NR requesters,
// with reordered frames routed back to their submitters in submission order.
module bitrev_arbiter
    import bitrev_pkg::*;
#(
    parameter int K    = K_DEF,
    parameter int DW   = DW_DEF,
    parameter int NR   = 2,
    parameter int TAGD = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NR-1:0]          in_valid_i,
    input  logic [NR-1:0][DW-1:0]  in_data_i,
    output logic [NR-1:0]          in_ready_o,
    output logic                   core_valid_o,
    output logic [DW-1:0]          core_data_o,
    input  logic                   core_ready_i,
    input  logic                   core_valid_i,
    input  logic [DW-1:0]          core_data_i,
    output logic                   core_ready_o,
    output logic [NR-1:0]          out_valid_o,
    output logic [DW-1:0]          out_data_o,
    output logic                   out_last_o,
    input  logic [NR-1:0]          out_ready_i,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int N  = 1 << K;
    localparam int GW = $clog2(NR);

    bra_state_e    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [K-1:0]  icnt_q, icnt_d;
    logic [K-1:0]  ocnt_q, ocnt_d;
    logic          err_q, err_d;

    logic          tag_push, tag_pop, tag_full, tag_empty;
    logic [GW-1:0] owner;

    function automatic logic [GW-1:0] rr_pick(input logic [NR-1:0] req, input logic [GW-1:0] last);
        logic [GW-1:0] pick;
        logic          found;
        int            idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= NR; i++) begin
            idx = (int'(last) + i) % NR;
            if (!found && req[idx]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    bitrev_tag_fifo #(
        .DEPTH (TAGD),
        .W     (GW)
    ) u_tags (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (tag_push),
        .data_i  (grant_d),
        .pop_i   (tag_pop),
        .head_o  (owner),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    // Input side: arbitrate in IDLE, then pass one whole frame straight through.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        icnt_d       = icnt_q;
        tag_push     = 1'b0;
        in_ready_o   = '0;
        core_valid_o = 1'b0;
        core_data_o  = '0;
        case (state_q)
            IDLE: begin
                // A draining pop frees the slot this same cycle.
                if ((|in_valid_i) && (!tag_full || tag_pop)) begin
                    grant_d      = rr_pick(in_valid_i, last_grant_q);
                    last_grant_d = grant_d;
                    tag_push     = 1'b1;
                    icnt_d       = '0;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                core_valid_o        = in_valid_i[grant_q];
                core_data_o         = in_data_i[grant_q];
                in_ready_o[grant_q] = core_ready_i;
                if (core_valid_o && core_ready_i) begin
                    icnt_d = icnt_q + 1'b1;
                    if (icnt_q == K'(N - 1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output side: the tag queue head owns whatever the core presents.
    always_comb begin
        out_valid_o  = '0;
        core_ready_o = 1'b0;
        out_last_o   = 1'b0;
        tag_pop      = 1'b0;
        ocnt_d       = ocnt_q;
        err_d        = err_q;
        if (!tag_empty) begin
            out_valid_o[owner] = core_valid_i;
            core_ready_o       = out_ready_i[owner];
            out_last_o         = (ocnt_q == K'(N - 1)) && core_valid_i;
            if (core_valid_i && out_ready_i[owner]) begin
                ocnt_d = ocnt_q + 1'b1;
                if (ocnt_q == K'(N - 1)) begin
                    tag_pop = 1'b1;
                end
            end
        end else if (core_valid_i) begin
            err_d = 1'b1;
        end
    end

    assign out_data_o = core_data_i;
    assign busy_o     = (state_q == LOAD) || !tag_empty;
    assign err_o      = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NR - 1);
            icnt_q       <= '0;
            ocnt_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            icnt_q       <= icnt_d;
            ocnt_q       <= ocnt_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_bitrev_arbiter.sv
// Bench for bitrev_arbiter with a behavioural three-bank bitrev core attached.
module tb_bitrev_arbiter;

    localparam int K    = 10;
    localparam int DW   = 32;
    localparam int NR   = 2;
    localparam int TAGD = 2;
    localparam int N    = 1 << K;
    localparam int NB   = 3;

    logic                  clk = 1'b0;
    logic                  rst_ni;
    logic [NR-1:0]         in_valid_i, in_ready_o, out_valid_o, out_ready_i;
    logic [NR-1:0][DW-1:0] in_data_i;
    logic                  core_valid_o, core_ready_i, core_valid_i, core_ready_o;
    logic                  out_last_o, busy_o, err_o;
    logic [DW-1:0]         core_data_o, core_data_i, out_data_o;

    always #5 clk = ~clk;

    bitrev_arbiter #(.K(K), .DW(DW), .NR(NR), .TAGD(TAGD)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .in_valid_i   (in_valid_i),
        .in_data_i    (in_data_i),
        .in_ready_o   (in_ready_o),
        .core_valid_o (core_valid_o),
        .core_data_o  (core_data_o),
        .core_ready_i (core_ready_i),
        .core_valid_i (core_valid_i),
        .core_data_i  (core_data_i),
        .core_ready_o (core_ready_o),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_last_o   (out_last_o),
        .out_ready_i  (out_ready_i),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    function automatic logic [K-1:0] brev(input logic [K-1:0] x);
        logic [K-1:0] r;
        for (int b = 0; b < K; b++) r[b] = x[K-1-b];
        return r;
    endfunction

    // Core model: NB frame banks written in order, read back bit-reversed.
    logic [DW-1:0] mem [NB][N];
    int            wp, rp, bc;
    logic [K-1:0]  wc, rc;
    logic          m_valid, m_ready, m_wr, m_rd, force_cv;

    assign m_ready      = (bc < NB);
    assign m_valid      = (bc > 0);
    assign m_wr         = core_valid_o && m_ready;
    assign m_rd         = m_valid && core_ready_o;
    assign core_ready_i = m_ready;
    assign core_valid_i = m_valid || force_cv;
    assign core_data_i  = m_valid ? mem[rp][brev(rc)] : '0;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wp <= 0; rp <= 0; bc <= 0; wc <= '0; rc <= '0;
        end else begin
            if (m_wr) begin
                mem[wp][wc] <= core_data_o;
                wc <= wc + 1'b1;
                if (wc == '1) wp <= (wp + 1) % NB;
            end
            if (m_rd) begin
                rc <= rc + 1'b1;
                if (rc == '1) rp <= (rp + 1) % NB;
            end
            bc <= bc + ((m_wr && wc == '1) ? 1 : 0) - ((m_rd && rc == '1) ? 1 : 0);
        end
    end

    typedef struct {
        int          req;
        logic [DW-1:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic [NR-1:0] mask;
        int            win;
        int            gap_at;
        int            gap_len;
        bit            hold;
        bit            drain;
        int            mode;
        bit            bubble;
    } vec_t;

    exp_t          expq[$];
    vec_t          vt[8];
    int            n_vec, n_bad, cyc, mode;
    int            last_out_cyc, prev_last_cyc, grant_cyc, last_out_at_grant;
    int            fid[NR];
    logic [NR-1:0] xin, rdy;

    function automatic logic [DW-1:0] word(input int r, input int f, input int i);
        return {8'(r), 8'(f), 16'(i)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {in_ready_o, core_valid_o, core_ready_o, out_valid_o, out_last_o, busy_o, err_o}, 0);
        check({tag, "_data"}, {core_data_o, out_data_o}, 0);
    endtask

    // One clock: sample and score outputs at the falling edge, then step out_ready.
    task automatic tick();
        int r;
        @(negedge clk);
        cyc++;
        rdy = in_ready_o;
        xin = in_valid_i & in_ready_o;
        if (rst_ni && !force_cv) begin
            if (core_valid_i) begin
                if (expq.size() == 0) begin
                    check("core_word_without_frame", 1, 0);
                end else begin
                    r = expq[0].req;
                    check("out_valid_route", out_valid_o, NR'(1) << r);
                    check("core_ready_track", core_ready_o, out_ready_i[r]);
                    check("out_last", out_last_o, expq[0].last);
                    if (out_ready_i[r]) begin
                        check("out_data", out_data_o, expq[0].data);
                        if (expq[0].last) last_out_cyc = cyc;
                        void'(expq.pop_front());
                    end
                end
            end else begin
                check("out_quiet", {out_valid_o, out_last_o}, 0);
            end
        end
        @(posedge clk);
        #1;
        case (mode)
            0:       out_ready_i = '1;
            1:       out_ready_i = NR'($urandom);
            default: out_ready_i = '0;
        endcase
    endtask

    task automatic wait_drain();
        int guard;
        mode  = 0;
        guard = 0;
        while ((expq.size() != 0 || busy_o) && guard < 8 * N) begin
            tick();
            guard++;
        end
        check("drain", {32'(expq.size()), 31'd0, busy_o}, 0);
    endtask

    task automatic run_frame(input vec_t v, input int abort_at);
        int            w, i, guard;
        bit            gapped, leak;
        logic [NR-1:0] others;
        if (v.drain) wait_drain();
        mode = v.mode;
        for (int r = 0; r < NR; r++) begin
            if (v.mask[r]) begin
                in_valid_i[r] = 1'b1;
                in_data_i[r]  = word(r, fid[r], 0);
            end
        end
        xin   = '0;
        guard = 0;
        while ((xin & v.mask) == '0 && guard < 8 * N) begin
            tick();
            guard++;
        end
        if ((xin & v.mask) == '0) begin
            check("grant_timeout", 0, 1);
            in_valid_i = '0;
            return;
        end
        grant_cyc         = cyc;
        last_out_at_grant = last_out_cyc;
        w = 0;
        for (int r = 0; r < NR; r++) if (xin[r] && v.mask[r]) w = r;
        check("single_grant", $onehot(xin), 1);
        check("grant", w, v.win);
        if (v.bubble) check("arb_bubble", grant_cyc - prev_last_cyc, 2);
        for (int j = 0; j < N; j++) begin
            expq.push_back('{w, word(w, fid[w], int'(brev(K'(j)))), j == N - 1});
        end
        if (!v.hold) in_valid_i = in_valid_i & (NR'(1) << w);
        others = ~(NR'(1) << w);
        i      = 1;
        gapped = 0;
        leak   = 0;
        guard  = 0;
        while (i < N && guard < 20 * N) begin
            if (i == abort_at) return;
            in_data_i[w] = word(w, fid[w], i);
            if (i == v.gap_at && !gapped) begin
                in_valid_i[w] = 1'b0;
                repeat (v.gap_len) begin
                    tick();
                    if ((rdy & others) != '0) leak = 1;
                end
                in_valid_i[w] = 1'b1;
                gapped = 1;
            end
            tick();
            guard++;
            if ((rdy & others) != '0) leak = 1;
            if (xin[w]) i++;
        end
        in_valid_i[w] = 1'b0;
        check("frame_complete", i, N);
        check("other_ready_during_frame", leak, 0);
        prev_last_cyc = cyc;
        fid[w]++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vq;
        bit   leak;
        //         mask   win gap  len hold drain mode bubble
        vt[0] = '{2'b01, 0,  -1,  0,  0,   1,    0,   0};
        vt[1] = '{2'b11, 1,  -1,  0,  1,   1,    0,   0};
        vt[2] = '{2'b11, 0,  -1,  0,  0,   0,    0,   1};
        vt[3] = '{2'b10, 1,  -1,  0,  0,   0,    1,   0};
        vt[4] = '{2'b11, 0,  500, 20, 1,   1,    0,   0};
        vt[5] = '{2'b10, 1,  -1,  0,  0,   0,    0,   1};
        vt[6] = '{2'b11, 0,  -1,  0,  0,   0,    1,   0};
        vt[7] = '{2'b11, 1,  -1,  0,  0,   0,    1,   0};

        n_vec = 0; n_bad = 0; cyc = 0; mode = 0;
        last_out_cyc = 0; prev_last_cyc = 0; grant_cyc = 0; last_out_at_grant = 0;
        for (int r = 0; r < NR; r++) fid[r] = 0;
        rst_ni      = 1'b0;
        force_cv    = 1'b0;
        in_valid_i  = '0;
        in_data_i   = '0;
        out_ready_i = '1;
        #1;
        check_reset_outputs("reset_async");
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        for (int vi = 0; vi < 8; vi++) run_frame(vt[vi], N);

        // Tag queue full: two frames parked behind out_ready=0 block a third grant.
        wait_drain();
        check("err_clear_after_traffic", err_o, 0);
        vq = '{2'b01, 0, -1, 0, 0, 0, 2, 0};
        run_frame(vq, N);
        vq = '{2'b10, 1, -1, 0, 0, 0, 2, 0};
        run_frame(vq, N);
        in_valid_i[0] = 1'b1;
        in_data_i[0]  = word(0, fid[0], 0);
        leak = 0;
        repeat (40) begin
            tick();
            if (rdy != '0) leak = 1;
        end
        check("full_queue_blocks_grant", leak, 0);
        check("busy_while_full", busy_o, 1);
        vq = '{2'b01, 0, -1, 0, 0, 0, 0, 0};
        run_frame(vq, N);
        check("grant_right_after_pop", grant_cyc - last_out_at_grant, 1);

        // Reset in the middle of a frame, then requester 0 must win again.
        wait_drain();
        vq = '{2'b11, 1, -1, 0, 1, 0, 0, 0};
        run_frame(vq, 300);
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("reset_mid_frame");
        expq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        vq = '{2'b11, 0, -1, 0, 0, 0, 0, 0};
        run_frame(vq, N);
        wait_drain();

        // Core presenting data with nothing in flight.
        force_cv = 1'b1;
        @(negedge clk);
        check("orphan_word_not_routed", {out_valid_o, core_ready_o}, 0);
        @(posedge clk);
        #1;
        force_cv = 1'b0;
        check("err_set", err_o, 1);
        repeat (5) tick();
        check("err_sticky", err_o, 1);
        rst_ni = 1'b0;
        #1;
        check("err_cleared_by_reset", err_o, 0);
        @(negedge clk);
        rst_ni = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
